// File: rtl/register_file_if.sv
// Bus bundle for the register file: one write port and two independent read ports.
// The master drives the write and read addresses; the slave returns the read data.
interface register_file_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
);
  logic                 write_enable;
  logic [ADDR_BITS-1:0] write_addr;
  logic [WIDTH-1:0]     write_data;
  logic [ADDR_BITS-1:0] read_addr_a;
  logic [ADDR_BITS-1:0] read_addr_b;
  logic [WIDTH-1:0]     read_data_a;
  logic [WIDTH-1:0]     read_data_b;

  modport master (
    output write_enable, write_addr, write_data, read_addr_a, read_addr_b,
    input  read_data_a, read_data_b
  );

  modport slave (
    input  write_enable, write_addr, write_data, read_addr_a, read_addr_b,
    output read_data_a, read_data_b
  );
endinterface

// File: rtl/register_file.sv
// Two-read / one-write register file with asynchronous clear, an optional
// hardwired-zero entry 0 and optional same-cycle write-to-read forwarding.
module register_file #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic            clock,
  input  logic            reset,
  register_file_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] entry_value [DEPTH];
  logic             write_hit;

  // A write to a hardwired zero entry, or any write under reset, is not a real write.
  assign write_hit = bus.write_enable && !reset &&
                     !((ZERO_REG != 0) && (bus.write_addr == '0));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign entry_value[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] value_reg;

        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            value_reg <= '0;
          end else if (bus.write_enable && (bus.write_addr == ADDR_BITS'(gi))) begin
            value_reg <= bus.write_data;
          end
        end

        assign entry_value[gi] = value_reg;
      end
    end
  endgenerate

  always_comb begin
    bus.read_data_a = entry_value[bus.read_addr_a];
    bus.read_data_b = entry_value[bus.read_addr_b];
    if ((BYPASS != 0) && write_hit && (bus.write_addr == bus.read_addr_a)) begin
      bus.read_data_a = bus.write_data;
    end
    if ((BYPASS != 0) && write_hit && (bus.write_addr == bus.read_addr_b)) begin
      bus.read_data_b = bus.write_data;
    end
    // Outputs stay at zero for the whole reset pulse, independent of the clock.
    if (reset) begin
      bus.read_data_a = '0;
      bus.read_data_b = '0;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: three instances cover the default build,
// the BYPASS=0/ZERO_REG=0 build and a narrow WIDTH=8/ADDR_BITS=3 build.
module tb_register_file;
  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  register_file_if #(.WIDTH(32), .ADDR_BITS(5)) bus_a ();
  register_file_if #(.WIDTH(32), .ADDR_BITS(5)) bus_b ();
  register_file_if #(.WIDTH(8),  .ADDR_BITS(3)) bus_c ();

  register_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave));
  register_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave));
  register_file #(.WIDTH(8),  .ADDR_BITS(3), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clock(clock), .reset(reset), .bus(bus_c.slave));

  int checks = 0;
  int errors = 0;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  logic [7:0]  m_c [8];

  task automatic expect_val(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic check_val(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=0x%08h expected=<none>", obs);
      return;
    end
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    assert (obs === exp) begin
      $display("chk %s observed=0x%08h", tag, obs);
    end else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    for (int i = 0; i < 8; i++) m_c[i] = '0;
  endtask

  task automatic write_a(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    bus_a.write_enable = 1'b1;
    bus_a.write_addr   = addr;
    bus_a.write_data   = data;
    @(posedge clock);
    #1;
    bus_a.write_enable = 1'b0;
    if (addr != 5'd0) m_a[addr] = data;
  endtask

  task automatic write_c(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clock);
    bus_c.write_enable = 1'b1;
    bus_c.write_addr   = addr;
    bus_c.write_data   = data;
    @(posedge clock);
    #1;
    bus_c.write_enable = 1'b0;
    if (addr != 3'd0) m_c[addr] = data;
  endtask

  task automatic read_a(input logic [4:0] ra, input logic [4:0] rb, input string tag);
    @(negedge clock);
    bus_a.read_addr_a = ra;
    bus_a.read_addr_b = rb;
    expect_val({tag, "_a"}, m_a[ra]);
    expect_val({tag, "_b"}, m_a[rb]);
    #1;
    check_val(bus_a.read_data_a);
    check_val(bus_a.read_data_b);
  endtask

  task automatic read_c(input logic [2:0] ra, input logic [2:0] rb, input string tag);
    @(negedge clock);
    bus_c.read_addr_a = ra;
    bus_c.read_addr_b = rb;
    expect_val({tag, "_a"}, {24'd0, m_c[ra]});
    expect_val({tag, "_b"}, {24'd0, m_c[rb]});
    #1;
    check_val({24'd0, bus_c.read_data_a});
    check_val({24'd0, bus_c.read_data_b});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus_a.write_enable = 1'b0; bus_a.write_addr = '0; bus_a.write_data = '0;
    bus_a.read_addr_a = '0;    bus_a.read_addr_b = '0;
    bus_b.write_enable = 1'b0; bus_b.write_addr = '0; bus_b.write_data = '0;
    bus_b.read_addr_a = '0;    bus_b.read_addr_b = '0;
    bus_c.write_enable = 1'b0; bus_c.write_addr = '0; bus_c.write_data = '0;
    bus_c.read_addr_a = '0;    bus_c.read_addr_b = '0;
    clear_models();

    // Reset pulse: outputs must be zero while reset is held.
    #1 reset = 1'b1;
    bus_a.read_addr_a = 5'd5;
    bus_a.read_addr_b = 5'd9;
    expect_val("in_reset_a", 32'h0);
    expect_val("in_reset_b", 32'h0);
    #1;
    check_val(bus_a.read_data_a);
    check_val(bus_a.read_data_b);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      read_a(5'(i), 5'(31 - i), $sformatf("post_reset_%0d", i));
    end

    write_a(5'd7, 32'hDEADBEEF);
    read_a(5'd7, 5'd7, "addr7");
    read_a(5'd6, 5'd8, "neighbours");

    // Write all-ones to address 0 on the zero-reg and the plain build.
    @(negedge clock);
    bus_a.write_enable = 1'b1; bus_a.write_addr = 5'd0; bus_a.write_data = 32'hFFFFFFFF;
    bus_a.read_addr_a  = 5'd0;
    bus_b.write_enable = 1'b1; bus_b.write_addr = 5'd0; bus_b.write_data = 32'hFFFFFFFF;
    bus_b.read_addr_a  = 5'd0;
    expect_val("zero_no_bypass_a", 32'h0);
    expect_val("nobypass_pre_zero_b", m_b[0]);
    #1;
    check_val(bus_a.read_data_a);
    check_val(bus_b.read_data_a);
    @(posedge clock);
    #1;
    bus_a.write_enable = 1'b0;
    bus_b.write_enable = 1'b0;
    m_b[0] = 32'hFFFFFFFF;
    expect_val("zero_reg_a", 32'h0);
    expect_val("plain_reg0_b", m_b[0]);
    check_val(bus_a.read_data_a);
    check_val(bus_b.read_data_a);

    // Preload 0x11 into address 3 of both builds.
    @(negedge clock);
    bus_a.write_enable = 1'b1; bus_a.write_addr = 5'd3; bus_a.write_data = 32'h11;
    bus_b.write_enable = 1'b1; bus_b.write_addr = 5'd3; bus_b.write_data = 32'h11;
    @(posedge clock);
    #1;
    bus_a.write_enable = 1'b0;
    bus_b.write_enable = 1'b0;
    m_a[3] = 32'h11;
    m_b[3] = 32'h11;

    // Overwrite with 0x22 while reading the same address.
    @(negedge clock);
    bus_a.write_enable = 1'b1; bus_a.write_addr = 5'd3; bus_a.write_data = 32'h22;
    bus_a.read_addr_a  = 5'd3;
    bus_b.write_enable = 1'b1; bus_b.write_addr = 5'd3; bus_b.write_data = 32'h22;
    bus_b.read_addr_a  = 5'd3;
    expect_val("bypass_pre_a", 32'h22);
    expect_val("nobypass_pre_b", m_b[3]);
    #1;
    check_val(bus_a.read_data_a);
    check_val(bus_b.read_data_a);
    @(posedge clock);
    #1;
    bus_a.write_enable = 1'b0;
    bus_b.write_enable = 1'b0;
    m_a[3] = 32'h22;
    m_b[3] = 32'h22;
    expect_val("bypass_post_a", m_a[3]);
    expect_val("nobypass_post_b", m_b[3]);
    check_val(bus_a.read_data_a);
    check_val(bus_b.read_data_a);

    write_a(5'd12, 32'h1234);
    read_a(5'd12, 5'd3, "preload12");

    // Reset asserted between edges must clear at once without a clock.
    @(negedge clock);
    bus_b.read_addr_a = 5'd3;
    #2 reset = 1'b1;
    clear_models();
    expect_val("async_clear_a", 32'h0);
    expect_val("async_clear_b", 32'h0);
    #1;
    check_val(bus_a.read_data_a);
    check_val(bus_b.read_data_a);

    bus_a.write_enable = 1'b1; bus_a.write_addr = 5'd12; bus_a.write_data = 32'h5555;
    expect_val("reset_no_bypass", 32'h0);
    #1;
    check_val(bus_a.read_data_a);
    @(posedge clock);
    #1;
    expect_val("reset_write_ignored", 32'h0);
    check_val(bus_a.read_data_a);
    @(negedge clock);
    bus_a.write_enable = 1'b0;
    reset = 1'b0;
    expect_val("after_reset_12", 32'h0);
    #1;
    check_val(bus_a.read_data_a);

    write_a(5'd12, 32'hABCD);
    read_a(5'd12, 5'd12, "first_write_after_reset");

    // Narrow build: i*17 into every non-zero address, then a discarded write to 0.
    for (int i = 1; i < 8; i++) write_c(3'(i), 8'(i * 17));
    write_c(3'd0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      read_c(3'(i), 3'(7 - i), $sformatf("narrow_%0d", i));
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, which sets the data bits per entry.
REQ-002 The block SHALL take parameter ADDR_BITS, default 5, which sets the address width; DEPTH = 2^ADDR_BITS entries.
REQ-003 The block SHALL take parameter BYPASS, default 1, where 1 forwards same-cycle write data to the read ports and 0 gives registered-only reads.
REQ-004 The block SHALL take parameter ZERO_REG, default 1, where 1 makes entry 0 hardwired to zero and unwritable.
REQ-005 The block SHALL have port clock  input  1  single clock, with all storage updated on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high clear of all entries.
REQ-007 The block SHALL have port write_enable  input  1  write request for the current cycle.
REQ-008 The block SHALL have port write_addr  input  ADDR_BITS  entry index to write.
REQ-009 The block SHALL have port write_data  input  WIDTH  value to write.
REQ-010 The block SHALL have port read_addr_a  input  ADDR_BITS  entry index for read port A.
REQ-011 The block SHALL have port read_addr_b  input  ADDR_BITS  entry index for read port B.
REQ-012 The block SHALL have port read_data_a  output  WIDTH  contents of entry read_addr_a.
REQ-013 The block SHALL have port read_data_b  output  WIDTH  contents of entry read_addr_b.
REQ-014 The block SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-015 Each entry SHALL be a WIDTH-bit register that loads write_data on the rising clock edge when write_enable=1 and write_addr selects it.
REQ-016 Entries not selected by write_addr, or any entry while write_enable=0, SHALL hold their value.
REQ-017 When ZERO_REG=1, a write to address 0 SHALL be discarded, and entry 0 SHALL read as all-zeros at all times.
REQ-018 Read ports SHALL be combinational with zero-cycle latency: read_data_x = contents of entry read_addr_x.
REQ-019 Ports A and B SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-020 When BYPASS=1, write_enable=1, write_addr==read_addr_x, and the address is not a discarded zero-register write, read_data_x SHALL equal write_data in the same cycle.
REQ-021 When BYPASS=0, read_data_x SHALL show the pre-edge stored value until the edge, then the new value.
REQ-022 The block SHALL have exactly one write port; no write-collision case exists.
REQ-023 Address decode SHALL cover all DEPTH entries, with no out-of-range address.
REQ-024 Write data SHALL be stored bit-exact, with no truncation or extension, for any WIDTH >= 1.

Reset
REQ-025 Asserting reset SHALL clear every entry to 0 immediately, with no clock edge required.
REQ-026 While reset=1, writes SHALL be ignored, bypass SHALL be suppressed, and both read_data outputs SHALL be 0.
REQ-027 After reset deasserts, the first rising edge with write_enable=1 SHALL perform a normal write.
REQ-028 If reset asserts mid-cycle during a pending write, that write SHALL be lost and the entry SHALL read 0.

Verification
REQ-029 The bench SHALL cover: reset pulse, then read all 32 addresses on both ports -> all read 0x00000000.
REQ-030 The bench SHALL cover: write 0xDEADBEEF to addr 7, then next cycle read_addr_a=7, read_addr_b=7 -> both ports read 0xDEADBEEF, and addr 6/8 read 0.
REQ-031 The bench SHALL cover, with ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> read addr 0 = 0x00000000; with ZERO_REG=0 the same write -> 0xFFFFFFFF.
REQ-032 The bench SHALL cover, with BYPASS=1: addr 3 holds 0x11, write 0x22 to addr 3 with read_addr_a=3 in the same cycle -> read_data_a=0x22 before the edge; with BYPASS=0 -> 0x11 before the edge and 0x22 after.
REQ-033 The bench SHALL cover: load 0x1234 to addr 12, then assert reset between edges -> read_data 0 at once with no clock; a write attempted during reset -> still 0 after reset drops.
REQ-034 The bench SHALL cover, with parameters WIDTH=8 and ADDR_BITS=3: write i*17 to each addr i=1..7, then read back -> exact values, addr 0=0.
